al_entry_controller: RTL and testbench
======================================

AL_ENTRY_CONTROLLER -- requirements
Module: al_entry_controller

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits in the entry buffer (range 2..8, even).
REQ-002 SHALL have parameter TIMEOUT_S, default 10: entry inactivity timeout in seconds (range 1..255).
REQ-003 SHALL have parameter NUM_ALARMS, default 4: number of alarm slots (range 1..16); SEL_W = max(1, clog2(NUM_ALARMS)).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 one_second  input  1  one-clk-wide pulse, once per second.
REQ-007 key  input  8  keypad scan code; KP_INVALID when idle.
REQ-008 key_buffer  output  4*DIGITS  BCD entry, newest digit in bits [3:0].
REQ-009 alarm_index  output  SEL_W  currently selected alarm slot.
REQ-010 load_alarm  output  1  one-cycle pulse: write key_buffer to slot alarm_index.
REQ-011 load_new_time  output  1  one-cycle pulse: write key_buffer to current time.
REQ-012 show_alarm  output  1  display slot alarm_index instead of time.
REQ-013 show_keyboard  output  1  display key_buffer instead of time.
REQ-014 entry_error  output  1  one-cycle pulse: commit rejected.
REQ-015 debug_state_out  output  4  state encoding; debug_seconds_out  output  8  timeout count.

Function
REQ-016 States SHALL be SHOW_TIME, KEY_STORE, KEY_HOLD, KEY_RELEASE_FINISH, KEY_ENTRY, COMMIT_CHECK, SET_ALARM, SET_TIME, SHOW_ALARM, SHOW_ALARM_RELEASE.
REQ-017 SHOW_TIME: digit -> clear buffer and digit count, go KEY_STORE; KP_STAR -> SHOW_ALARM; KP_PLUS -> alarm_index+1 (wrap NUM_ALARMS-1 -> 0), go SHOW_ALARM; other keys ignored.
REQ-018 KEY_STORE (one cycle): digit shifts buffer left 4 bits inserting its BCD value; KP_BACKSPACE shifts right inserting 0; digit count increments saturating at DIGITS, decrements saturating at 0; go KEY_HOLD.
REQ-019 KEY_HOLD -> KEY_RELEASE_FINISH on KP_KEY_RELEASED; KEY_RELEASE_FINISH -> KEY_ENTRY on KP_INVALID, loading timeout with TIMEOUT_S.
REQ-020 KEY_ENTRY: timeout==0 -> SHOW_TIME, buffer cleared, no load; digit or KP_BACKSPACE -> KEY_STORE; KP_STAR or KP_MINUS -> COMMIT_CHECK, remembering which.
REQ-021 COMMIT_CHECK (one cycle): reject if digit count < DIGITS, or (DIGITS>=4) hours field (digits [4*DIGITS-1 : 4*DIGITS-8]) > 23 or minutes field > 59; reject pulses entry_error and goes SHOW_TIME; accept goes SET_ALARM (STAR) or SET_TIME (MINUS).
REQ-022 SET_ALARM / SET_TIME SHALL assert load_alarm / load_new_time for exactly one cycle with key_buffer stable, then go SHOW_TIME.
REQ-023 SHOW_ALARM holds show_alarm=1 until KP_KEY_RELEASED -> SHOW_ALARM_RELEASE; that state eats KP_INVALID -> SHOW_TIME.
REQ-024 show_keyboard SHALL be 1 in KEY_STORE through SET_TIME inclusive, else 0.
REQ-025 Timeout decrements on one_second when nonzero, never wraps below 0; reload and one_second in same cycle: reload wins.
REQ-026 Unused/illegal state encodings SHALL return to SHOW_TIME next cycle, all pulses deasserted.
REQ-027 All outputs SHALL be registered; key-to-state-change latency is one clk.

Reset
REQ-028 reset low SHALL immediately force SHOW_TIME, key_buffer=0, digit count=0, timeout=0, alarm_index=0, all pulse and display outputs 0, including mid-entry or mid-commit.
REQ-029 First state change after reset release SHALL occur on the second rising clk edge.

Structure
REQ-030 Keycodes (KP_0..KP_9, their BCD values, KP_STAR, KP_MINUS, KP_PLUS, KP_BACKSPACE, KP_KEY_RELEASED, KP_INVALID) SHALL live in shared keycodes.vh; state encodings in shared al_states.vh.
REQ-031 Buffer shift/backspace/count logic SHALL be one sub-module, bcd_entry_buffer, parametrised by DIGITS.

Verification
REQ-032 Keys 1,2,3,4 each with release, then KP_STAR -> key_buffer=16'h1234, one load_alarm pulse, alarm_index=0.
REQ-033 KP_PLUS twice from SHOW_TIME, release, then 0,7,3,0, KP_MINUS -> alarm_index=2, one load_new_time pulse, buffer 16'h0730.
REQ-034 Keys 2,5,0,0, KP_STAR -> entry_error pulse, no load_alarm; keys 1,2,BACKSPACE,3 -> buffer 16'h0013, count 2.
REQ-035 Key 9 then 10 one_second pulses with no key -> SHOW_TIME, buffer 0, no load; reset low mid-KEY_HOLD -> all outputs 0 immediately.
REQ-036 DIGITS=6, NUM_ALARMS=3: six digits 235959, KP_STAR -> buffer 24'h235959 accepted; KP_PLUS x3 -> alarm_index wraps to 0.

Source files
------------

// File: rtl/al_entry_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// al_entry_controller_pkg : keypad scan codes, FSM state encodings, helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package al_entry_controller_pkg;

    localparam logic [7:0] KP_0            = 8'h30;
    localparam logic [7:0] KP_1            = 8'h31;
    localparam logic [7:0] KP_2            = 8'h32;
    localparam logic [7:0] KP_3            = 8'h33;
    localparam logic [7:0] KP_4            = 8'h34;
    localparam logic [7:0] KP_5            = 8'h35;
    localparam logic [7:0] KP_6            = 8'h36;
    localparam logic [7:0] KP_7            = 8'h37;
    localparam logic [7:0] KP_8            = 8'h38;
    localparam logic [7:0] KP_9            = 8'h39;
    localparam logic [7:0] KP_STAR         = 8'h2A;
    localparam logic [7:0] KP_PLUS         = 8'h2B;
    localparam logic [7:0] KP_MINUS        = 8'h2D;
    localparam logic [7:0] KP_BACKSPACE    = 8'h08;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hFE;
    localparam logic [7:0] KP_INVALID      = 8'hFF;

    localparam int STATE_W = 4;
    localparam logic [3:0] SHOW_TIME          = 4'd0;
    localparam logic [3:0] KEY_STORE          = 4'd1;
    localparam logic [3:0] KEY_HOLD           = 4'd2;
    localparam logic [3:0] KEY_RELEASE_FINISH = 4'd3;
    localparam logic [3:0] KEY_ENTRY          = 4'd4;
    localparam logic [3:0] COMMIT_CHECK       = 4'd5;
    localparam logic [3:0] SET_ALARM          = 4'd6;
    localparam logic [3:0] SET_TIME           = 4'd7;
    localparam logic [3:0] SHOW_ALARM         = 4'd8;
    localparam logic [3:0] SHOW_ALARM_RELEASE = 4'd9;

    // Digit count never exceeds 8, so four bits cover every legal DIGITS
    localparam int CNT_W = 4;

    typedef enum logic {
        COMMIT_ALARM = 1'b0,
        COMMIT_TIME  = 1'b1
    } commit_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_digit(input logic [7:0] k);
        return (k >= KP_0) && (k <= KP_9);
    endfunction

    function automatic logic [3:0] bcd_of(input logic [7:0] k);
        logic [7:0] d;
        d = k - KP_0;
        return d[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/al_entry_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// al_entry_controller_if : keypad input / display + load output bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface al_entry_controller_if
    import al_entry_controller_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int NUM_ALARMS = 4
);
    localparam int SEL_W = sel_width(NUM_ALARMS);

    logic                  one_second;
    logic [7:0]            key;
    logic [4*DIGITS-1:0]   key_buffer;
    logic [SEL_W-1:0]      alarm_index;
    logic                  load_alarm;
    logic                  load_new_time;
    logic                  show_alarm;
    logic                  show_keyboard;
    logic                  entry_error;
    logic [3:0]            debug_state_out;
    logic [7:0]            debug_seconds_out;

    modport master (
        output one_second, key,
        input  key_buffer, alarm_index, load_alarm, load_new_time, show_alarm,
               show_keyboard, entry_error, debug_state_out, debug_seconds_out
    );

    modport slave (
        input  one_second, key,
        output key_buffer, alarm_index, load_alarm, load_new_time, show_alarm,
               show_keyboard, entry_error, debug_state_out, debug_seconds_out
    );
endinterface
`default_nettype wire

// File: rtl/al_entry_controller_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_entry_buffer : BCD shift register with backspace and saturating count
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_entry_buffer
    import al_entry_controller_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire                  clk,
    input  wire                  reset,
    input  wire                  clear_i,
    input  wire                  store_i,
    input  wire                  backspace_i,
    input  wire  [3:0]           digit_i,
    output logic [4*DIGITS-1:0]  buffer_o,
    output logic [CNT_W-1:0]     count_o
);
    localparam int               BUF_W    = 4 * DIGITS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGITS);

    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        buffer_d = buffer_q;
        count_d  = count_q;
        if (clear_i) begin
            buffer_d = '0;
            count_d  = '0;
        end else if (store_i) begin
            if (backspace_i) begin
                buffer_d = {4'h0, buffer_q[BUF_W-1:4]};
                if (count_q != '0) count_d = count_q - 1'b1;
            end else begin
                buffer_d = {buffer_q[BUF_W-5:0], digit_i};
                if (count_q != FULL_CNT) count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            buffer_q <= buffer_d;
            count_q  <= count_d;
        end
    end

    assign buffer_o = buffer_q;
    assign count_o  = count_q;

endmodule
`default_nettype wire

// File: rtl/al_entry_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// al_entry_controller : keypad entry FSM committing BCD time / alarm values
// Rev 1.0
// ---------------------------------------------------------------------------
module al_entry_controller
    import al_entry_controller_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int TIMEOUT_S  = 10,
    parameter int NUM_ALARMS = 4
) (
    input  wire                  clk,
    input  wire                  reset,
    al_entry_controller_if.slave bus
);
    localparam int               SEL_W    = sel_width(NUM_ALARMS);
    localparam int               BUF_W    = 4 * DIGITS;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_ALARMS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGITS);

    logic [STATE_W-1:0] state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    commit_e            commit_q, commit_d;
    logic [7:0]         key_q;
    logic [7:0]         timeout_q;
    logic               run_q;
    logic               load_alarm_q, load_time_q, show_alarm_q, show_kb_q, error_q;

    logic [7:0]         w_key;
    logic               w_clear, w_reload, w_error, w_time_bad;
    logic [BUF_W-1:0]   w_buffer;
    logic [CNT_W-1:0]   w_count;

    assign w_key = bus.key;

    bcd_entry_buffer #(.DIGITS(DIGITS)) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (w_clear),
        .store_i     (state_q == KEY_STORE),
        .backspace_i (key_q == KP_BACKSPACE),
        .digit_i     (bcd_of(key_q)),
        .buffer_o    (w_buffer),
        .count_o     (w_count)
    );

    // BCD nibbles order like binary, so a hex compare checks the range
    generate
        if (DIGITS >= 4) begin : g_time_check
            assign w_time_bad = (w_buffer[BUF_W-1:BUF_W-8]  > 8'h23) ||
                                (w_buffer[BUF_W-9:BUF_W-16] > 8'h59);
        end else begin : g_no_time_check
            assign w_time_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        commit_d = commit_q;
        w_clear  = 1'b0;
        w_reload = 1'b0;
        w_error  = 1'b0;
        if (run_q) begin
            case (state_q)
                SHOW_TIME: begin
                    if (is_digit(w_key)) begin
                        w_clear = 1'b1;
                        state_d = KEY_STORE;
                    end else if (w_key == KP_STAR) begin
                        state_d = SHOW_ALARM;
                    end else if (w_key == KP_PLUS) begin
                        idx_d   = (idx_q >= LAST_IDX) ? '0 : idx_q + 1'b1;
                        state_d = SHOW_ALARM;
                    end
                end
                KEY_STORE: state_d = KEY_HOLD;
                KEY_HOLD: if (w_key == KP_KEY_RELEASED) state_d = KEY_RELEASE_FINISH;
                KEY_RELEASE_FINISH: begin
                    if (w_key == KP_INVALID) begin
                        w_reload = 1'b1;
                        state_d  = KEY_ENTRY;
                    end
                end
                KEY_ENTRY: begin
                    if (timeout_q == 8'd0) begin
                        w_clear = 1'b1;
                        state_d = SHOW_TIME;
                    end else if (is_digit(w_key) || (w_key == KP_BACKSPACE)) begin
                        state_d = KEY_STORE;
                    end else if (w_key == KP_STAR) begin
                        commit_d = COMMIT_ALARM;
                        state_d  = COMMIT_CHECK;
                    end else if (w_key == KP_MINUS) begin
                        commit_d = COMMIT_TIME;
                        state_d  = COMMIT_CHECK;
                    end
                end
                COMMIT_CHECK: begin
                    if ((w_count < FULL_CNT) || w_time_bad) begin
                        w_error = 1'b1;
                        state_d = SHOW_TIME;
                    end else begin
                        state_d = (commit_q == COMMIT_ALARM) ? SET_ALARM : SET_TIME;
                    end
                end
                SET_ALARM, SET_TIME: state_d = SHOW_TIME;
                SHOW_ALARM: if (w_key == KP_KEY_RELEASED) state_d = SHOW_ALARM_RELEASE;
                SHOW_ALARM_RELEASE: if (w_key == KP_INVALID) state_d = SHOW_TIME;
                default: state_d = SHOW_TIME;
            endcase
        end
    end

    // run_q holds the FSM for one edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q        <= 1'b0;
            state_q      <= SHOW_TIME;
            idx_q        <= '0;
            commit_q     <= COMMIT_ALARM;
            key_q        <= KP_INVALID;
            timeout_q    <= 8'd0;
            load_alarm_q <= 1'b0;
            load_time_q  <= 1'b0;
            show_alarm_q <= 1'b0;
            show_kb_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            state_q  <= state_d;
            idx_q    <= idx_d;
            commit_q <= commit_d;
            if (state_d == KEY_STORE) key_q <= w_key;
            if (w_reload)
                timeout_q <= 8'(TIMEOUT_S);
            else if (bus.one_second && (timeout_q != 8'd0))
                timeout_q <= timeout_q - 8'd1;
            load_alarm_q <= (state_d == SET_ALARM);
            load_time_q  <= (state_d == SET_TIME);
            show_alarm_q <= (state_d == SHOW_ALARM);
            show_kb_q    <= (state_d >= KEY_STORE) && (state_d <= SET_TIME);
            error_q      <= w_error;
        end
    end

    assign bus.key_buffer        = w_buffer;
    assign bus.alarm_index       = idx_q;
    assign bus.load_alarm        = load_alarm_q;
    assign bus.load_new_time     = load_time_q;
    assign bus.show_alarm        = show_alarm_q;
    assign bus.show_keyboard     = show_kb_q;
    assign bus.entry_error       = error_q;
    assign bus.debug_state_out   = state_q;
    assign bus.debug_seconds_out = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_al_entry_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_al_entry_controller : directed bench with commit-pulse scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_al_entry_controller;
    import al_entry_controller_pkg::*;

    localparam logic [2:0] EV_ALARM = 3'b100;
    localparam logic [2:0] EV_TIME  = 3'b010;
    localparam logic [2:0] EV_ERR   = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] buffer;
        logic [31:0] index;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    al_entry_controller_if #(.DIGITS(4), .NUM_ALARMS(4)) bus4 ();
    al_entry_controller_if #(.DIGITS(6), .NUM_ALARMS(3)) bus6 ();

    al_entry_controller #(.DIGITS(4), .TIMEOUT_S(10), .NUM_ALARMS(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));
    al_entry_controller #(.DIGITS(6), .TIMEOUT_S(10), .NUM_ALARMS(3)) dut6 (
        .clk(clk), .reset(reset), .bus(bus6.slave));

    ev_t q4[$];
    ev_t q6[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input int d, input logic [7:0] k);
        if (d == 4) bus4.key = k;
        else        bus6.key = k;
    endtask

    task automatic expect_ev(input int d, input logic [2:0] kind, input logic [31:0] b,
                             input logic [31:0] idx);
        ev_t e;
        e.kind = kind; e.buffer = b; e.index = idx;
        if (d == 4) q4.push_back(e);
        else        q6.push_back(e);
    endtask

    task automatic press(input int d, input logic [7:0] k);
        set_key(d, k);               step(1);
        set_key(d, KP_KEY_RELEASED); step(3);
        set_key(d, KP_INVALID);      step(3);
    endtask

    task automatic commit(input int d, input logic [7:0] k);
        set_key(d, k);          step(1);
        set_key(d, KP_INVALID); step(4);
    endtask

    task automatic enter(input int d, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) press(d, KP_0 + {4'h0, v[4*i +: 4]});
    endtask

    task automatic check_idle4(input string tag);
        check({tag, " flags"}, 32'({bus4.load_alarm, bus4.load_new_time, bus4.show_alarm,
                                   bus4.show_keyboard, bus4.entry_error}), 32'd0);
        check({tag, " buffer"},  32'(bus4.key_buffer), 32'd0);
        check({tag, " state"},   32'(bus4.debug_state_out), 32'(SHOW_TIME));
        check({tag, " index"},   32'(bus4.alarm_index), 32'd0);
        check({tag, " seconds"}, 32'(bus4.debug_seconds_out), 32'd0);
    endtask

    initial begin
        logic [2:0] o4, o6;
        ev_t        e4, e6;

        reset = 1'b0;
        bus4.key = KP_INVALID; bus4.one_second = 1'b0;
        bus6.key = KP_INVALID; bus6.one_second = 1'b0;

        // Scoreboard: every commit/error pulse cycle consumes one expected event
        fork
            forever begin
                @(negedge clk);
                o4 = {bus4.load_alarm, bus4.load_new_time, bus4.entry_error};
                o6 = {bus6.load_alarm, bus6.load_new_time, bus6.entry_error};
                if (reset && (o4 != 3'b000)) begin
                    if (q4.size() == 0) check("dut4 unexpected pulse", 32'(o4), 32'd0);
                    else begin
                        e4 = q4.pop_front();
                        check("dut4 pulse kind",   32'(o4), 32'(e4.kind));
                        check("dut4 pulse buffer", 32'(bus4.key_buffer), e4.buffer);
                        check("dut4 pulse index",  32'(bus4.alarm_index), e4.index);
                    end
                end
                if (reset && (o6 != 3'b000)) begin
                    if (q6.size() == 0) check("dut6 unexpected pulse", 32'(o6), 32'd0);
                    else begin
                        e6 = q6.pop_front();
                        check("dut6 pulse kind",   32'(o6), 32'(e6.kind));
                        check("dut6 pulse buffer", 32'(bus6.key_buffer), e6.buffer);
                        check("dut6 pulse index",  32'(bus6.alarm_index), e6.index);
                    end
                end
            end
        join_none

        step(3);
        check_idle4("reset");
        check("reset dut6 buffer", 32'(bus6.key_buffer), 32'd0);

        // A key held through reset release acts on the second edge only
        bus4.key = KP_STAR;
        @(negedge clk);
        reset = 1'b1;
        step(1);
        check("release edge1 state", 32'(bus4.debug_state_out), 32'(SHOW_TIME));
        step(1);
        check("release edge2 state", 32'(bus4.debug_state_out), 32'(SHOW_ALARM));
        check("star show_alarm",     32'(bus4.show_alarm), 32'd1);
        bus4.key = KP_KEY_RELEASED; step(2);
        bus4.key = KP_INVALID;      step(2);
        check("show_alarm exit state", 32'(bus4.debug_state_out), 32'(SHOW_TIME));
        check("show_alarm exit flag",  32'(bus4.show_alarm), 32'd0);

        // 1234 committed as alarm 0
        enter(4, 32'h1234, 4);
        check("entry buffer 1234",  32'(bus4.key_buffer), 32'h1234);
        check("entry state",        32'(bus4.debug_state_out), 32'(KEY_ENTRY));
        check("entry show_keyboard", 32'(bus4.show_keyboard), 32'd1);
        check("entry timeout",      32'(bus4.debug_seconds_out), 32'd10);
        expect_ev(4, EV_ALARM, 32'h1234, 32'd0);
        commit(4, KP_STAR);
        check("after alarm state", 32'(bus4.debug_state_out), 32'(SHOW_TIME));
        check("after alarm kbd",   32'(bus4.show_keyboard), 32'd0);

        // Two PLUS presses select slot 2, then 07:30 as new time
        bus4.key = KP_PLUS; step(1);
        check("plus1 index",      32'(bus4.alarm_index), 32'd1);
        check("plus1 show_alarm", 32'(bus4.show_alarm), 32'd1);
        bus4.key = KP_KEY_RELEASED; step(3);
        bus4.key = KP_INVALID;      step(3);
        press(4, KP_PLUS);
        check("plus2 index", 32'(bus4.alarm_index), 32'd2);
        enter(4, 32'h0730, 4);
        expect_ev(4, EV_TIME, 32'h0730, 32'd2);
        commit(4, KP_MINUS);

        // Range and count rejections, accepted boundaries
        enter(4, 32'h2500, 4);
        expect_ev(4, EV_ERR, 32'h2500, 32'd2);
        commit(4, KP_STAR);
        enter(4, 32'h1260, 4);
        expect_ev(4, EV_ERR, 32'h1260, 32'd2);
        commit(4, KP_MINUS);
        enter(4, 32'h0012, 2);
        press(4, KP_BACKSPACE);
        press(4, KP_3);
        check("backspace buffer", 32'(bus4.key_buffer), 32'h0013);
        expect_ev(4, EV_ERR, 32'h0013, 32'd2);
        commit(4, KP_STAR);
        enter(4, 32'h2359, 4);
        expect_ev(4, EV_ALARM, 32'h2359, 32'd2);
        commit(4, KP_STAR);
        enter(4, 32'h12345, 5);
        check("overflow buffer", 32'(bus4.key_buffer), 32'h2345);
        expect_ev(4, EV_TIME, 32'h2345, 32'd2);
        commit(4, KP_MINUS);
        press(4, KP_1);
        press(4, KP_BACKSPACE);
        press(4, KP_BACKSPACE);
        enter(4, 32'h1234, 4);
        expect_ev(4, EV_ALARM, 32'h1234, 32'd2);
        commit(4, KP_STAR);

        // Reload beats a coincident one_second; zero timeout abandons entry
        bus4.one_second = 1'b1;
        bus4.key = KP_9;            step(1);
        bus4.key = KP_KEY_RELEASED; step(2);
        bus4.key = KP_INVALID;      step(1);
        bus4.one_second = 1'b0;
        check("reload priority", 32'(bus4.debug_seconds_out), 32'd10);
        for (int i = 0; i < 9; i++) begin
            bus4.one_second = 1'b1; step(1);
            bus4.one_second = 1'b0; step(1);
        end
        check("timeout count 1", 32'(bus4.debug_seconds_out), 32'd1);
        check("timeout state",   32'(bus4.debug_state_out), 32'(KEY_ENTRY));
        check("timeout buffer",  32'(bus4.key_buffer), 32'h0009);
        bus4.one_second = 1'b1; step(1);
        bus4.one_second = 1'b0; step(1);
        check("expired state",  32'(bus4.debug_state_out), 32'(SHOW_TIME));
        check("expired buffer", 32'(bus4.key_buffer), 32'd0);
        bus4.one_second = 1'b1; step(1);
        bus4.one_second = 1'b0; step(1);
        check("timeout no wrap", 32'(bus4.debug_seconds_out), 32'd0);

        // Asynchronous reset while a key is held
        bus4.key = KP_5; step(2);
        check("hold state",  32'(bus4.debug_state_out), 32'(KEY_HOLD));
        check("hold buffer", 32'(bus4.key_buffer), 32'h0005);
        #2 reset = 1'b0;
        #1 check_idle4("mid-hold reset");
        bus4.key = KP_INVALID;
        step(2);
        @(negedge clk);
        reset = 1'b1;
        step(2);

        // Six-digit instance with three alarm slots
        enter(6, 32'h235959, 6);
        check("dut6 buffer", 32'(bus6.key_buffer), 32'h235959);
        expect_ev(6, EV_ALARM, 32'h235959, 32'd0);
        commit(6, KP_STAR);
        enter(6, 32'h23595, 5);
        expect_ev(6, EV_ERR, 32'h023595, 32'd0);
        commit(6, KP_STAR);
        press(6, KP_PLUS);
        check("dut6 plus1", 32'(bus6.alarm_index), 32'd1);
        press(6, KP_PLUS);
        check("dut6 plus2", 32'(bus6.alarm_index), 32'd2);
        press(6, KP_PLUS);
        check("dut6 wrap",  32'(bus6.alarm_index), 32'd0);

        step(5);
        check("dut4 pending events", 32'(q4.size()), 32'd0);
        check("dut6 pending events", 32'(q6.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
